// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store sequencer: access size codes, FSM
// state encoding and size/alignment helpers.
package mips_mem_pkg;

    // Access size codes as presented on req_size.
    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Number of single-byte memory accesses needed for a size code.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        logic [2:0] nbytes;
        case (size)
            SZ_BYTE: nbytes = 3'd1;
            SZ_HALF: nbytes = 3'd2;
            SZ_WORD: nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
        return nbytes;
    endfunction

    // A request is rejected for an illegal size or a misaligned address.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_sequencer_load_extend.sv
// Sign/zero extension of the reassembled big-endian load data. The
// accumulator is right-justified, so the loaded value always sits in the
// low bytes regardless of size.
module load_extend
    import mips_mem_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    // Pick the sign bit for the access width and fill the upper bits.
    always_comb begin
        result = acc;
        case (size)
            SZ_BYTE: result = {{24{acc[7]  & ~is_unsigned}}, acc[7:0]};
            SZ_HALF: result = {{16{acc[15] & ~is_unsigned}}, acc[15:0]};
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/load_store_sequencer.sv
// Load/store sequencer between the MEM stage and a byte-wide data memory.
// One request at a time is split into 1/2/4 byte accesses, MSB first
// (big-endian), and answered with a single response.
module load_store_sequencer
    import mips_mem_pkg::*;
#(
    parameter int MEMORY_SIZE = 16384,
    parameter int ADDR_WIDTH  = $clog2(MEMORY_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);

    state_t                state_q,    state_d;
    logic [1:0]            cnt_q,      cnt_d;
    logic [1:0]            nlast_q,    nlast_d;     // index of the final byte (N-1)
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [31:0]           wdata_q,    wdata_d;
    logic [1:0]            size_q,     size_d;
    logic                  store_q,    store_d;
    logic                  unsigned_q, unsigned_d;
    logic [31:0]           acc_q,      acc_d;
    logic [31:0]           rdata_q,    rdata_d;
    logic                  err_q,      err_d;

    logic [31:0]           acc_shift;
    logic [31:0]           ext_result;
    logic [2:0]            req_nbytes;
    logic [1:0]            byte_sel;

    // The final byte is shifted in on the same edge the response is built,
    // so extension works on the accumulator including the current byte.
    assign acc_shift  = {acc_q[23:0], mem_rdata};
    assign req_nbytes = size_to_nbytes(req_size);

    load_extend u_load_extend (
        .acc         (acc_shift),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .result      (ext_result)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            nlast_q    <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            size_q     <= SZ_BYTE;
            store_q    <= 1'b0;
            unsigned_q <= 1'b0;
            acc_q      <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nlast_q    <= nlast_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            store_q    <= store_d;
            unsigned_q <= unsigned_d;
            acc_q      <= acc_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nlast_d    = nlast_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        store_d    = store_q;
        unsigned_d = unsigned_q;
        acc_d      = acc_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    size_d     = req_size;
                    store_d    = req_store;
                    unsigned_d = req_unsigned;
                    cnt_d      = 2'd0;
                    acc_d      = 32'd0;
                    rdata_d    = 32'd0;
                    if (req_is_bad(req_size, req_addr[1:0])) begin
                        // Rejected without touching memory.
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        nlast_d = 2'(req_nbytes - 3'd1);
                        state_d = ST_XFER;
                    end
                end
            end

            ST_XFER: begin
                if (!store_q) begin
                    acc_d = acc_shift;
                end
                if (cnt_q == nlast_q) begin
                    rdata_d = store_q ? 32'd0 : ext_result;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end

            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Store bytes leave MSB first: byte N-1-cnt of the right-justified data.
    assign byte_sel = nlast_q - cnt_q;

    // Memory port, driven only while transferring; the write strobe is
    // additionally gated by reset so a reset cycle never writes.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        if (state_q == ST_XFER) begin
            mem_addr = addr_q + ADDR_WIDTH'(cnt_q);
            if (store_q) begin
                mem_we    = ~rst;
                mem_wdata = wdata_q[{byte_sel, 3'b000} +: 8];
            end
        end
    end

endmodule
